vanilla_remote_mem_responder: RTL and testbench
===============================================

# vanilla_remote_mem_responder

Memory-side endpoint for vanilla-core remote requests: accepts one `remote_req_s` at a time and services it against a local word-addressed SRAM. Stores update memory with a byte mask. Loads and AMOs (swap/or/add) return a `remote_load_resp_s` to the requester. It sits at the far end of the core's remote-request path, e.g. as a tile-local scratchpad or a test endpoint, and is the responder counterpart of the core's remote request/response structs in `bsg_vanilla_pkg`.

## Interface
- `els_p`, default 1024: number of 32-bit words in local memory; power of two, ≥ 2.
- `lg_els_lp`, default `$clog2(els_p)`: word-index width (derived).
- `clk_i`  in  1  clock; all state updates on rising edge.
- `reset_n_i`  in  1  reset, asynchronous and active-low.
- `req_v_i`  in  1  request valid.
- `req_i`  in  `$bits(remote_req_s)`  request (`write_not_read`, `is_amo_op`, `amo_type`, `mask`, `load_info`, `reg_id`, `data`, `addr`).
- `req_ready_o`  out  1  request accepted when `req_v_i & req_ready_o`.
- `resp_v_o`  out  1  response valid.
- `resp_o`  out  `$bits(remote_load_resp_s)`  response.
- `resp_ready_i`  in  1  response consumed when `resp_v_o & resp_ready_i`.

## Operation
- Word index is `addr[2+:lg_els_lp]`. `addr[1:0]` and bits above the index are ignored, so addresses wrap modulo `els_p*4`.
- Decode priority: `is_amo_op` > `write_not_read` > load.
- FSM has three states: `eIDLE`, `eREAD`, `eRESP`.
- `eIDLE`:
  - `req_ready_o = 1`.
  - On accept of a store: write `data` to the indexed word. Only bytes with `mask[i]=1` (byte i = bits `8i+7:8i`) are written. No response. Stay in `eIDLE`.
  - On accept of a load or AMO: latch `reg_id`, `load_info`, `data`, `amo_type`, index and the is-AMO flag; issue a synchronous read; go to `eREAD`.
- `eREAD`:
  - `req_ready_o = 0`.
  - Read word `old` is valid. Capture the response register; go to `eRESP`.
  - If AMO, write `new` to the same index in the same cycle. `mask` is ignored for AMOs (full word).
  - `new` by type:
    - swap: `data`.
    - or: `old | data`.
    - add: `old + data`, 32-bit, wraps mod 2^32.
    - encoding 2'b11: reserved; no memory write, response still returned.
- `eRESP`:
  - `resp_v_o = 1`, `req_ready_o = 0`.
  - On `resp_ready_i` go to `eIDLE`.
  - `resp_o` is held stable while waiting.
- Response contents:
  - `data = old`, always the full 32-bit word. Byte/hex extraction is the requester's job.
  - `reg_id` is the latched `reg_id`.
  - For a load, `float_wb`, `is_unsigned_op`, `is_byte_op`, `is_hex_op` and `part_sel` are copied from the latched `load_info`.
  - For an AMO, `float_wb = 0`, `is_unsigned_op = 0`, `is_byte_op = 0`, `is_hex_op = 0`, `part_sel = 0`.
- Memory contents are not reset; reads of never-written words return X.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state `eIDLE`, `resp_v_o = 0`, `req_ready_o = 1` after deassert.
- `resp_o` is 0 at reset.
- While `reset_n_i = 0`, `req_ready_o = 0`.
- Store: memory updated at the accept edge. A load accepted on the next cycle returns the new data.
- Load/AMO latency: accept at cycle N, `eREAD` at N+1, `resp_v_o = 1` at N+2.
- If `resp_ready_i` is high at N+2, the next request can be accepted at N+3. Minimum is 3 cycles per load/AMO and 1 cycle per store.
- AMO write lands at the end of N+1, so a request accepted at N+3 observes the updated value.
- Backpressure: `resp_v_o` stays asserted and `resp_o` is unchanged for any number of cycles with `resp_ready_i = 0`.
- `req_v_i` is ignored in `eREAD` and `eRESP`. The requester must hold the request until accepted.
- Reset asserted mid-operation:
  - The pending response is dropped and `resp_v_o` goes low immediately.
  - An AMO in `eREAD` when reset asserts does not write memory.
- `resp_ready_i` without `resp_v_o` has no effect.

## Test plan
- Store 0xDEADBEEF to addr 0x10 with mask 4'hF, then load addr 0x10 with `reg_id` 5 → `resp_v_o` 2 cycles after accept, `data` 0xDEADBEEF, `reg_id` 5, load_info fields echoed.
- Store 0x11223344 mask 4'hF, then store 0xAABBCCDD mask 4'b0101 to the same word, then load → 0x11BB33DD.
- AMO add 0x00000002 to a word holding 0xFFFFFFFF → response `data` 0xFFFFFFFF; a following load returns 0x00000001. AMO or 0x0F0 on 0x00F → returns 0x00F, memory becomes 0x0FF. AMO swap 7 on 0x0FF → returns 0x0FF, memory becomes 7.
- Load with `resp_ready_i = 0` for 5 cycles → `resp_v_o` and `resp_o` stable throughout, `req_ready_o = 0`, a competing `req_v_i` is not accepted; `resp_ready_i` rises → the next request is accepted the following cycle.
- Address wrap with `els_p = 1024`: store 0x5 to addr 0x0, then load addr 0x1000 → 0x5.
- Assert `reset_n_i` low in `eREAD` of an AMO add → `resp_v_o = 0` immediately; after release, a load of that word returns the pre-AMO value.

Source files
------------

// File: rtl/vanilla_remote_mem_responder.sv
`default_nettype none
// ============================================================================
// vanilla_remote_mem_responder: word-addressed SRAM endpoint for remote
// store / load / AMO requests.                              Revision: 1.0
// ============================================================================
package vanilla_remote_mem_pkg;
    typedef enum logic [1:0] {
        e_amo_swap = 2'b00,
        e_amo_or   = 2'b01,
        e_amo_add  = 2'b10,
        e_amo_rsvd = 2'b11
    } amo_type_e;

    typedef struct packed {
        logic       float_wb;
        logic       is_unsigned_op;
        logic       is_byte_op;
        logic       is_hex_op;
        logic [1:0] part_sel;
    } load_info_s;

    typedef struct packed {
        logic        write_not_read;
        logic        is_amo_op;
        amo_type_e   amo_type;
        logic [3:0]  mask;
        load_info_s  load_info;
        logic [4:0]  reg_id;
        logic [31:0] data;
        logic [31:0] addr;
    } remote_req_s;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  reg_id;
        logic        float_wb;
        logic        is_unsigned_op;
        logic        is_byte_op;
        logic        is_hex_op;
        logic [1:0]  part_sel;
    } remote_load_resp_s;
endpackage

module vanilla_remote_mem_responder
    import vanilla_remote_mem_pkg::*;
#(
    parameter int els_p     = 1024,
    parameter int lg_els_lp = $clog2(els_p)
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              req_v_i,
    input  remote_req_s       req_i,
    output logic              req_ready_o,
    output logic              resp_v_o,
    output remote_load_resp_s resp_o,
    input  logic              resp_ready_i
);
    typedef enum logic [1:0] {
        eIDLE = 2'd0,
        eREAD = 2'd1,
        eRESP = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [lg_els_lp-1:0]   idx_q, idx_d;
    logic                   is_amo_q, is_amo_d;
    amo_type_e              amo_type_q, amo_type_d;
    logic [31:0]            data_q, data_d;
    logic [4:0]             reg_id_q, reg_id_d;
    load_info_s             load_info_q, load_info_d;
    remote_load_resp_s      resp_q, resp_d;

    logic [31:0]            mem [els_p];
    logic [31:0]            mem_rdata_q;
    logic                   mem_re;
    logic                   mem_we;
    logic [lg_els_lp-1:0]   mem_waddr;
    logic [31:0]            mem_wdata;
    logic [3:0]             mem_wmask;

    logic [lg_els_lp-1:0]   req_idx;
    logic                   accept;
    logic [31:0]            amo_new;
    logic                   amo_wr;
    logic                   unused_addr_bits;

    assign req_idx          = req_i.addr[2+:lg_els_lp];
    assign unused_addr_bits = ^{req_i.addr[31:2+lg_els_lp], req_i.addr[1:0]};

    // Gating with reset keeps the endpoint closed while reset is held.
    assign req_ready_o = (state_q == eIDLE) & reset_n_i;
    assign accept      = req_v_i & req_ready_o;
    assign resp_v_o    = (state_q == eRESP);
    assign resp_o      = resp_q;

    always_comb begin
        amo_new = mem_rdata_q;
        amo_wr  = 1'b1;
        case (amo_type_q)
            e_amo_swap: amo_new = data_q;
            e_amo_or:   amo_new = mem_rdata_q | data_q;
            e_amo_add:  amo_new = mem_rdata_q + data_q;
            default:    amo_wr  = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        is_amo_d    = is_amo_q;
        amo_type_d  = amo_type_q;
        data_d      = data_q;
        reg_id_d    = reg_id_q;
        load_info_d = load_info_q;
        resp_d      = resp_q;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = req_idx;
        mem_wdata   = req_i.data;
        mem_wmask   = req_i.mask;

        case (state_q)
            eIDLE: begin
                if (accept) begin
                    if (!req_i.is_amo_op && req_i.write_not_read) begin
                        mem_we = 1'b1;
                    end else begin
                        mem_re      = 1'b1;
                        idx_d       = req_idx;
                        is_amo_d    = req_i.is_amo_op;
                        amo_type_d  = req_i.amo_type;
                        data_d      = req_i.data;
                        reg_id_d    = req_i.reg_id;
                        load_info_d = req_i.load_info;
                        state_d     = eREAD;
                    end
                end
            end
            eREAD: begin
                resp_d        = '0;
                resp_d.data   = mem_rdata_q;
                resp_d.reg_id = reg_id_q;
                if (!is_amo_q) begin
                    resp_d.float_wb       = load_info_q.float_wb;
                    resp_d.is_unsigned_op = load_info_q.is_unsigned_op;
                    resp_d.is_byte_op     = load_info_q.is_byte_op;
                    resp_d.is_hex_op      = load_info_q.is_hex_op;
                    resp_d.part_sel       = load_info_q.part_sel;
                end else if (amo_wr) begin
                    mem_we    = 1'b1;
                    mem_waddr = idx_q;
                    mem_wdata = amo_new;
                    mem_wmask = 4'hF;
                end
                state_d = eRESP;
            end
            eRESP: begin
                if (resp_ready_i) begin
                    state_d = eIDLE;
                end
            end
            default: state_d = eIDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= eIDLE;
            idx_q       <= '0;
            is_amo_q    <= 1'b0;
            amo_type_q  <= e_amo_swap;
            data_q      <= '0;
            reg_id_q    <= '0;
            load_info_q <= '0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            is_amo_q    <= is_amo_d;
            amo_type_q  <= amo_type_d;
            data_q      <= data_d;
            reg_id_q    <= reg_id_d;
            load_info_q <= load_info_d;
            resp_q      <= resp_d;
        end
    end

    // Storage is intentionally not reset; only the control path is.
    always_ff @(posedge clk_i) begin
        if (mem_re) begin
            mem_rdata_q <= mem[req_idx];
        end
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) begin
                    mem[mem_waddr][8*b+:8] <= mem_wdata[8*b+:8];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vanilla_remote_mem_responder.sv
`default_nettype none
// Self-checking bench for vanilla_remote_mem_responder: directed vector table,
// hand-written corner sequences and randomized traffic against a word model.
module tb_vanilla_remote_mem_responder;
    import vanilla_remote_mem_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_v;
    remote_req_s       req;
    logic              req_ready;
    logic              resp_v;
    remote_load_resp_s resp;
    logic              resp_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vanilla_remote_mem_responder #(.els_p(1024)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .req_v_i      (req_v),
        .req_i        (req),
        .req_ready_o  (req_ready),
        .resp_v_o     (resp_v),
        .resp_o       (resp),
        .resp_ready_i (resp_ready)
    );

    typedef struct {
        int          kind;   // 0 store, 1 load, 2 amo
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [1:0]  amo;
        logic [4:0]  rid;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [18];
    logic [31:0] model [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic remote_req_s mk(input int kind, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [3:0] mask,
                                       input logic [1:0] amo, input logic [4:0] rid,
                                       input load_info_s li);
        remote_req_s r;
        r.write_not_read = (kind != 1);  // AMOs also carry write_not_read=1
        r.is_amo_op      = (kind == 2);
        r.amo_type       = amo_type_e'(amo);
        r.mask           = mask;
        r.load_info      = li;
        r.reg_id         = rid;
        r.data           = data;
        r.addr           = addr;
        return r;
    endfunction

    function automatic remote_load_resp_s exp_resp(input int kind, input logic [31:0] old,
                                                   input logic [4:0] rid, input load_info_s li);
        remote_load_resp_s e;
        e = '0;
        e.data   = old;
        e.reg_id = rid;
        if (kind == 1) begin
            e.float_wb       = li.float_wb;
            e.is_unsigned_op = li.is_unsigned_op;
            e.is_byte_op     = li.is_byte_op;
            e.is_hex_op      = li.is_hex_op;
            e.part_sel       = li.part_sel;
        end
        return e;
    endfunction

    task automatic issue(input remote_req_s r);
        int n = 0;
        @(negedge clk);
        req_v = 1'b1;
        req   = r;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("issue_timeout", 64'(req_ready), 64'(1'b1));
        @(posedge clk);
        #1 req_v = 1'b0;
    endtask

    task automatic finish_resp(input string name, input remote_load_resp_s e, input int stall);
        @(negedge clk);
        chk({name, "_read_v"}, 64'(resp_v), 64'(1'b0));
        @(negedge clk);
        chk({name, "_resp_v"}, 64'(resp_v), 64'(1'b1));
        chk({name, "_resp"}, 64'(resp), 64'(e));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({name, "_hold_v"}, 64'(resp_v), 64'(1'b1));
            chk({name, "_hold_resp"}, 64'(resp), 64'(e));
            chk({name, "_hold_rdy"}, 64'(req_ready), 64'(1'b0));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic op(input string name, input int kind, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] mask, input logic [1:0] amo,
                      input logic [4:0] rid, input load_info_s li, input logic [31:0] old,
                      input int stall);
        issue(mk(kind, addr, data, mask, amo, rid, li));
        if (kind != 0) finish_resp(name, exp_resp(kind, old, rid, li), stall);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        load_info_s li;
        remote_load_resp_s e;

        tbl[0]  = '{0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'd0, 5'd0, 32'h0};
        tbl[1]  = '{1, 32'h0000_0010, 32'h0,         4'h0, 2'd0, 5'd5, 32'hDEAD_BEEF};
        tbl[2]  = '{0, 32'h0000_0020, 32'h1122_3344, 4'hF, 2'd0, 5'd0, 32'h0};
        tbl[3]  = '{0, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 2'd0, 5'd0, 32'h0};
        tbl[4]  = '{1, 32'h0000_0022, 32'h0,         4'h0, 2'd0, 5'd9, 32'h11BB_33DD};
        tbl[5]  = '{0, 32'h0000_0030, 32'hFFFF_FFFF, 4'hF, 2'd0, 5'd0, 32'h0};
        tbl[6]  = '{2, 32'h0000_0030, 32'h0000_0002, 4'h0, 2'd2, 5'd3, 32'hFFFF_FFFF};
        tbl[7]  = '{1, 32'h0000_0030, 32'h0,         4'h0, 2'd0, 5'd4, 32'h0000_0001};
        tbl[8]  = '{0, 32'h0000_0040, 32'h0000_000F, 4'hF, 2'd0, 5'd0, 32'h0};
        tbl[9]  = '{2, 32'h0000_0040, 32'h0000_00F0, 4'h0, 2'd1, 5'd7, 32'h0000_000F};
        tbl[10] = '{1, 32'h0000_0040, 32'h0,         4'h0, 2'd0, 5'd8, 32'h0000_00FF};
        tbl[11] = '{2, 32'h0000_0040, 32'h0000_0007, 4'h3, 2'd0, 5'd31, 32'h0000_00FF};
        tbl[12] = '{1, 32'h0000_0040, 32'h0,         4'h0, 2'd0, 5'd1, 32'h0000_0007};
        tbl[13] = '{0, 32'h0000_0000, 32'h0000_0005, 4'hF, 2'd0, 5'd0, 32'h0};
        tbl[14] = '{1, 32'h0000_1000, 32'h0,         4'h0, 2'd0, 5'd2, 32'h0000_0005};
        tbl[15] = '{0, 32'h0000_0050, 32'h0000_1234, 4'hF, 2'd0, 5'd0, 32'h0};
        tbl[16] = '{2, 32'h0000_0050, 32'h0000_9999, 4'hF, 2'd3, 5'd6, 32'h0000_1234};
        tbl[17] = '{1, 32'h0000_0050, 32'h0,         4'h0, 2'd0, 5'd10, 32'h0000_1234};

        reset_n    = 1'b0;
        req_v      = 1'b0;
        req        = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(1'b0));
        chk("rst_resp_v", 64'(resp_v), 64'(1'b0));
        chk("rst_resp", 64'(resp), 64'(0));
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'(1'b1));
        chk("post_rst_resp_v", 64'(resp_v), 64'(1'b0));

        for (int i = 0; i < 18; i++) begin
            li = load_info_s'(6'((i * 13 + 5) & 63));
            op($sformatf("vec%0d", i), tbl[i].kind, tbl[i].addr, tbl[i].data, tbl[i].mask,
               tbl[i].amo, tbl[i].rid, li, tbl[i].exp, 0);
        end

        // Backpressure: response held, competing store blocked until drain.
        li = load_info_s'(6'h2A);
        e  = exp_resp(1, 32'hDEAD_BEEF, 5'd12, li);
        issue(mk(1, 32'h10, 32'h0, 4'h0, 2'd0, 5'd12, li));
        @(negedge clk);
        chk("bp_read_v", 64'(resp_v), 64'(1'b0));
        @(negedge clk);
        chk("bp_resp_v", 64'(resp_v), 64'(1'b1));
        chk("bp_resp", 64'(resp), 64'(e));
        req_v = 1'b1;
        req   = mk(0, 32'h78, 32'h77, 4'hF, 2'd0, 5'd0, '0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_v", 64'(resp_v), 64'(1'b1));
            chk("bp_hold_resp", 64'(resp), 64'(e));
            chk("bp_hold_rdy", 64'(req_ready), 64'(1'b0));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_next_rdy", 64'(req_ready), 64'(1'b1));
        chk("bp_next_v", 64'(resp_v), 64'(1'b0));
        @(posedge clk);
        #1 req_v = 1'b0;
        op("bp_verify", 1, 32'h78, 32'h0, 4'h0, 2'd0, 5'd13, '0, 32'h77, 0);

        // Reset during the read phase of an AMO add must cancel its write.
        op("rst_seed", 0, 32'h64, 32'h100, 4'hF, 2'd0, 5'd0, '0, 32'h0, 0);
        issue(mk(2, 32'h64, 32'h5, 4'hF, 2'd2, 5'd14, '0));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_resp_v", 64'(resp_v), 64'(1'b0));
        chk("mid_rst_ready", 64'(req_ready), 64'(1'b0));
        chk("mid_rst_resp", 64'(resp), 64'(0));
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        op("mid_rst_verify", 1, 32'h64, 32'h0, 4'h0, 2'd0, 5'd15, '0, 32'h100, 0);

        // Randomized traffic on words 64..79 with aliased address bits.
        for (int w = 0; w < 16; w++) begin
            model[w] = $urandom;
            op("rnd_init", 0, 32'((64 + w) << 2), model[w], 4'hF, 2'd0, 5'd0, '0, 32'h0, 0);
        end
        for (int t = 0; t < 200; t++) begin
            int          kind;
            int          w;
            logic [31:0] addr;
            logic [31:0] data;
            logic [31:0] old;
            logic [3:0]  mask;
            logic [1:0]  amo;
            kind = $urandom_range(0, 2);
            w    = $urandom_range(0, 15);
            addr = ($urandom & 32'hFFFF_F003) | 32'((64 + w) << 2);
            data = $urandom;
            mask = 4'($urandom);
            amo  = 2'($urandom);
            li   = load_info_s'(6'($urandom));
            old  = model[w];
            if (kind == 0) begin
                for (int b = 0; b < 4; b++)
                    if (mask[b]) model[w][8*b+:8] = data[8*b+:8];
            end else if (kind == 2) begin
                case (amo)
                    2'd0: model[w] = data;
                    2'd1: model[w] = old | data;
                    2'd2: model[w] = old + data;
                    default: model[w] = old;
                endcase
            end
            op($sformatf("rnd%0d", t), kind, addr, data, mask, amo, 5'($urandom), li, old,
               $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
